regfile_sequencer: RTL and testbench

//   Operand-fetch / write-back sequencer that owns the single shared port of the
//   32x8 register file (address, data_in, enable in; data_out combinational out).

---
 rtl/regfile_sequencer.sv | 124 ++++++++++++
 tb/tb_regfile_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Operand-fetch/write-back sequencer owning the single register-file port; R0_ZERO_EN makes r0 read 0, never written.
// Latency accept->write 5 edges; op_ready only in IDLE, holds ex_valid/ex_a/ex_b until ex_ready, waits on res_valid.
module regfile_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs,
    input  logic [ADDR_W-1:0] op_rt,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic              op_wb,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_enable,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WAIT_RES, S_WB
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;
    logic              r_wb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_en;
    logic              r_exv;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;

    logic [DATA_W-1:0] w_rd_val;
    logic              w_skip_wb;

    // rf_address always carries the index being read in RD_A/RD_B
`ifdef R0_ZERO_EN
    assign w_rd_val  = (r_addr == '0) ? '0 : rf_data_out;
    assign w_skip_wb = !r_wb || (r_rd == '0);
`else
    assign w_rd_val  = rf_data_out;
    assign w_skip_wb = !r_wb;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rt    <= '0;
            r_rd    <= '0;
            r_wb    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_en    <= 1'b0;
            r_exv   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_rt    <= op_rt;
                        r_rd    <= op_rd;
                        r_wb    <= op_wb;
                        r_addr  <= op_rs;
                        r_state <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    r_a     <= w_rd_val;
                    r_addr  <= r_rt;
                    r_state <= S_RD_B;
                end
                S_RD_B: begin
                    r_b     <= w_rd_val;
                    r_exv   <= 1'b1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ex_ready) begin
                        r_exv   <= 1'b0;
                        r_state <= w_skip_wb ? S_IDLE : S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        r_din   <= res_data;
                        r_addr  <= r_rd;
                        r_en    <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_en    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_en    <= 1'b0;
                    r_exv   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rf_address = r_addr;
    assign rf_data_in = r_din;
    assign rf_enable  = r_en;
    assign ex_valid   = r_exv;
    assign ex_a       = r_a;
    assign ex_b       = r_b;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file plus a reference register image checked per op.
module tb_regfile_sequencer;

`ifdef R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [4:0] op_rs = '0, op_rt = '0, op_rd = '0;
    logic       op_wb = 1'b0;
    logic [4:0] rf_address;
    logic [7:0] rf_data_in;
    logic       rf_enable;
    logic [7:0] rf_data_out;
    logic       ex_valid;
    logic       ex_ready = 1'b0;
    logic [7:0] ex_a, ex_b;
    logic       res_valid = 1'b0;
    logic [7:0] res_data = '0;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    // register file environment: combinational read, write on negedge
    logic [7:0] regs [32];
    bit         mem_init = 1'b0;
    int         wr_count = 0;
    logic [7:0] ref_mem [32];

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd), .op_wb(op_wb),
        .rf_address(rf_address), .rf_data_in(rf_data_in), .rf_enable(rf_enable),
        .rf_data_out(rf_data_out),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
        .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    assign rf_data_out = regs[rf_address];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? 8'hFF : 8'h00;
            mem_init <= 1'b1;
        end else if (rf_enable) begin
            regs[rf_address] <= rf_data_in;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [4:0] idx);
        return (R0Z && idx == 5'd0) ? 8'h00 : ref_mem[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full op. stall=0 means ex_ready already high; rdelay=0 means res_valid already high.
    task automatic do_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic wb, input logic [7:0] res,
                         input int stall, input int rdelay, input bit abort);
        logic [7:0] exp_a, exp_b;
        int         wr0;
        bit         skip;
        exp_a = ref_rd(rs);
        exp_b = ref_rd(rt);
        skip  = !wb || (R0Z && rd == 5'd0);
        wr0   = wr_count;
        chk("op_ready_idle", op_ready, 1);
        op_rs = rs; op_rt = rt; op_rd = rd; op_wb = wb; op_valid = 1'b1;
        res_data  = res;
        ex_ready  = (stall == 0);
        res_valid = (rdelay == 0);
        tick();
        op_valid = 1'b0;
        op_rs = 5'($urandom); op_rt = 5'($urandom); op_rd = 5'($urandom); op_wb = 1'($urandom);
        tick();
        chk("busy_rdb", busy, 1);
        chk("op_ready_rdb", op_ready, 0);
        chk("ex_valid_rdb", ex_valid, 0);
        tick();
        chk("ex_valid_exec", ex_valid, 1);
        chk("ex_a", ex_a, exp_a);
        chk("ex_b", ex_b, exp_b);
        for (int i = 0; i < stall; i++) begin
            op_valid = (i % 2 == 0);
            tick();
            chk("stall_ex_valid", ex_valid, 1);
            chk("stall_ex_a", ex_a, exp_a);
            chk("stall_ex_b", ex_b, exp_b);
            chk("stall_op_ready", op_ready, 0);
        end
        op_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        chk("ex_valid_drop", ex_valid, 0);
        if (skip) begin
            res_valid = 1'b0;
            chk("nowb_idle", op_ready, 1);
            chk("nowb_addr_hold", rf_address, rt);
            tick();
            chk("nowb_no_write", wr_count, wr0);
            chk("nowb_rf_enable", rf_enable, 0);
            return;
        end
        for (int i = 0; i < rdelay; i++) begin
            chk("wait_busy", busy, 1);
            chk("wait_rf_enable", rf_enable, 0);
            tick();
        end
        if (abort) begin
            reset = 1'b1;
            res_valid = 1'b1;
            tick();
            reset = 1'b0;
            res_valid = 1'b0;
            chk("abort_op_ready", op_ready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_rf_enable", rf_enable, 0);
            chk("abort_ex_a", ex_a, 0);
            chk("abort_addr", rf_address, 0);
            tick();
            chk("abort_no_write", wr_count, wr0);
            chk("abort_reg_kept", regs[rd], ref_mem[rd]);
            return;
        end
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("wb_rf_enable", rf_enable, 1);
        chk("wb_addr", rf_address, rd);
        chk("wb_data", rf_data_in, res);
        tick();
        ref_mem[rd] = res;
        chk("wb_done_enable", rf_enable, 0);
        chk("wb_done_idle", op_ready, 1);
        chk("wb_reg", regs[rd], ref_mem[rd]);
        chk("wb_count", wr_count, wr0 + 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = (i == 29) ? 8'hFF : 8'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_op_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rf_enable", rf_enable, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_b", ex_b, 0);
        chk("rst_addr", rf_address, 0);
        chk("rst_data_in", rf_data_in, 0);
        tick();

        // preload r3, then minimum-latency op reading r3 and r29
        do_op(5'd0, 5'd0, 5'd3, 1'b1, 8'h12, 0, 0, 1'b0);
        do_op(5'd3, 5'd29, 5'd5, 1'b1, 8'h11, 0, 0, 1'b0);
        chk("r5_final", regs[5], 8'h11);
        // execute stall of 4 cycles with op_valid pulses
        do_op(5'd5, 5'd3, 5'd7, 1'b1, 8'hA5, 4, 2, 1'b0);
        // no write-back, rs==rt
        do_op(5'd29, 5'd29, 5'd9, 1'b0, 8'h33, 1, 0, 1'b0);
        // destination aliases both sources
        do_op(5'd7, 5'd7, 5'd7, 1'b1, 8'h5A, 0, 1, 1'b0);
        // reset while waiting for the result
        do_op(5'd3, 5'd5, 5'd3, 1'b1, 8'hEE, 0, 2, 1'b1);
        // register 0 handling
        do_op(5'd1, 5'd2, 5'd0, 1'b1, 8'h55, 0, 0, 1'b0);
        do_op(5'd0, 5'd29, 5'd0, 1'b1, 8'h66, 0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            do_op(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        for (int i = 0; i < 32; i++) begin
            if (!(R0Z && i == 0)) chk("final_regs", regs[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
